present_iter_core: RTL and testbench
====================================

PRESENT_ITER_CORE -- requirements
Module: present_iter_core

Interface
REQ-001 Parameter BLOCK_W, default 16, block width in bits; multiple of 4, minimum 8.
REQ-002 Parameter KEY_W, default 20, master key width; KEY_W >= BLOCK_W.
REQ-003 Parameter ROUNDS, default 7, S-box rounds per block; range 1..31.
REQ-004 Parameter KEY_ROT, default 15, key-schedule left-rotate amount; range 1..KEY_W-1.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  request present.
REQ-008 in_ready  output  1  core can accept a request.
REQ-009 in_decrypt  input  1  1 = decrypt, 0 = encrypt; sampled on accept.
REQ-010 in_block  input  BLOCK_W  plaintext or ciphertext; sampled on accept.
REQ-011 in_key  input  KEY_W  master key; sampled on accept.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer takes the result.
REQ-014 out_block  output  BLOCK_W  result; stable while out_valid=1.

Function
REQ-015 Key schedule SHALL be: k0 = in_key[KEY_W-1 -: BLOCK_W] taken from the key register; forward step i (1..ROUNDS) = rotate left by KEY_ROT, S-box the top nibble, XOR 5-bit i into bits [4:0]; k_i = top BLOCK_W bits after step i.
REQ-016 Inverse step i SHALL exactly undo forward step i (XOR i, inverse S-box top nibble, rotate right by KEY_ROT).
REQ-017 Encrypt SHALL compute, for i=0..ROUNDS-1: state ^= k_i, S-box every nibble, pLayer; then state ^= k_ROUNDS.
REQ-018 pLayer SHALL move bit j to (j*BLOCK_W/4) mod (BLOCK_W-1) for j < BLOCK_W-1; bit BLOCK_W-1 stays fixed.
REQ-019 Decrypt SHALL compute, for i=ROUNDS..1: state ^= k_i, inverse pLayer, inverse S-box; then state ^= k0.
REQ-020 FSM states SHALL be IDLE, KEXP, ROUND, DONE; reset state is IDLE.
REQ-021 in_ready SHALL be 1 only in IDLE; accept occurs when in_valid & in_ready.
REQ-022 IDLE->ROUND on encrypt accept, or on decrypt accept when key-cache hit (REQ-025); IDLE->KEXP on decrypt accept with cache miss.
REQ-023 KEXP SHALL apply ROUNDS forward steps, one per cycle, then go to ROUND holding k_ROUNDS.
REQ-024 ROUND SHALL execute one round per cycle for ROUNDS cycles; the last cycle also applies whitening (encrypt k_ROUNDS, decrypt k0 via combinational inverse step 1); then go to DONE.
REQ-025 Key cache: after each KEXP, store in_key and k_ROUNDS register value; a later decrypt accept with identical in_key SHALL load the cached expanded key and skip KEXP.
REQ-026 Latency, accept edge to out_valid=1: encrypt ROUNDS cycles; decrypt miss 2*ROUNDS; decrypt hit ROUNDS.
REQ-027 DONE SHALL assert out_valid and hold out_block until out_ready=1, then go to IDLE; back-to-back throughput is one block per ROUNDS+2 cycles at minimum.
REQ-028 in_block, in_key and in_decrypt changes outside the accept cycle SHALL have no effect on an operation in progress.
REQ-029 out_block SHALL read 0 whenever out_valid=0.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, out_valid=0, out_block=0, and in_ready=1 after release; it clears the data, key and round-counter registers and invalidates the key cache.
REQ-031 Reset during KEXP or ROUND SHALL abort the operation; no result is produced.
REQ-032 Reset deassertion is synchronous to clk upstream; no internal synchroniser is required.

Structure
REQ-033 Shared package present_pkg SHALL hold the 4-bit S-box and inverse S-box tables, the FSM state enum, and the pLayer/inverse pLayer functions parameterised by width.
REQ-034 Forward and inverse key steps SHALL live in one sub-module, present_key_step (inputs key, round index, direction; output next key).
REQ-035 The datapath SHALL be a single round instance reused each cycle; it SHALL NOT be unrolled.

Verification
REQ-036 Defaults; encrypt block 16'h0000, key 20'h00000 -> out_valid exactly 7 cycles after accept; out_block matches the golden model.
REQ-037 Decrypt the REQ-036 result, same key, fresh cache after reset -> out_valid after 14 cycles, out_block=16'h0000.
REQ-038 Repeat the REQ-037 decrypt, same key -> cache hit, out_valid after 7 cycles, same result; change one key bit -> 14 cycles.
REQ-039 out_ready held 0 for 5 cycles in DONE -> out_block stable, in_ready=0 throughout; release -> IDLE next cycle.
REQ-040 rst_n pulsed low at ROUND cycle 3 -> out_valid stays 0, next decrypt takes the miss path with 14-cycle latency.
REQ-041 BLOCK_W=32, KEY_W=40, ROUNDS=12, 1000 random encrypt/decrypt round trips -> all plaintexts recovered, latencies 12/24/12.

Source files
------------

// File: rtl/present_pkg.sv
// Shared definitions for the iterative PRESENT-style core: S-box tables,
// FSM state encoding and width-generic substitution/permutation helpers.
package present_pkg;

  // Helpers operate on a fixed maximum width; callers zero-extend and truncate.
  localparam int MAX_W = 128;
  localparam int IDX_W = $clog2(MAX_W);

  // Nibble i of each table holds the substitution for input value i.
  localparam logic [63:0] SBOX_TABLE     = 64'h21748FE3DA09B65C;
  localparam logic [63:0] INV_SBOX_TABLE = 64'hA970364BD21C8FE5;

  typedef enum logic [1:0] {
    IDLE,
    KEXP,
    ROUND,
    DONE
  } state_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX_TABLE[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    return INV_SBOX_TABLE[{x, 2'b00} +: 4];
  endfunction

  // Destination of bit j; the top bit of the block is a fixed point.
  function automatic int p_dest(input int j, input int w);
    if (j == w - 1) return j;
    return (j * (w / 4)) % (w - 1);
  endfunction

  function automatic logic [MAX_W-1:0] p_layer(input logic [MAX_W-1:0] s, input int w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int j = 0; j < MAX_W; j++) begin
      if (j < w) r[IDX_W'(p_dest(j, w))] = s[IDX_W'(j)];
    end
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] p_layer_inv(input logic [MAX_W-1:0] s, input int w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int j = 0; j < MAX_W; j++) begin
      if (j < w) r[IDX_W'(j)] = s[IDX_W'(p_dest(j, w))];
    end
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] s_layer(input logic [MAX_W-1:0] s, input int w,
                                               input logic inv);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int n = 0; n < MAX_W / 4; n++) begin
      if (n < w / 4) begin
        r[IDX_W'(4 * n) +: 4] = inv ? inv_sbox(s[IDX_W'(4 * n) +: 4])
                                    : sbox(s[IDX_W'(4 * n) +: 4]);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/present_key_step.sv
// One key-schedule step in either direction; the inverse step exactly undoes
// the forward step carrying the same round index.
module present_key_step
  import present_pkg::*;
#(
  parameter int KEY_W   = 20,
  parameter int KEY_ROT = 15
) (
  input  logic [KEY_W-1:0] key,
  input  logic [4:0]       round_idx,
  input  logic             decrypt,
  output logic [KEY_W-1:0] next_key
);

  logic [KEY_W-1:0] rotated;
  logic [KEY_W-1:0] fwd;
  logic [KEY_W-1:0] undone;
  logic [KEY_W-1:0] inv;

  always_comb begin
    rotated = (key << KEY_ROT) | (key >> (KEY_W - KEY_ROT));
    fwd = rotated;
    fwd[KEY_W-1 -: 4] = sbox(rotated[KEY_W-1 -: 4]);
    fwd[4:0] = rotated[4:0] ^ round_idx;

    // Undo in reverse order: round constant, top-nibble S-box, then rotation.
    undone = key;
    undone[4:0] = key[4:0] ^ round_idx;
    undone[KEY_W-1 -: 4] = inv_sbox(key[KEY_W-1 -: 4]);
    inv = (undone >> KEY_ROT) | (undone << (KEY_W - KEY_ROT));

    next_key = decrypt ? inv : fwd;
  end

endmodule

// File: rtl/present_iter_core.sv
// Iterative block cipher core: one round per cycle through a single shared
// round datapath, with a one-entry cache of the fully expanded decrypt key.
module present_iter_core
  import present_pkg::*;
#(
  parameter int BLOCK_W = 16,
  parameter int KEY_W   = 20,
  parameter int ROUNDS  = 7,
  parameter int KEY_ROT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_decrypt,
  input  logic [BLOCK_W-1:0] in_block,
  input  logic [KEY_W-1:0]   in_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_block
);

  state_t state;
  state_t state_next;

  logic [BLOCK_W-1:0] data;
  logic [BLOCK_W-1:0] mixed;
  logic [BLOCK_W-1:0] stage;
  logic [BLOCK_W-1:0] round_out;
  logic [BLOCK_W-1:0] data_next;
  logic [KEY_W-1:0]   key_reg;
  logic [KEY_W-1:0]   step_key;
  logic [KEY_W-1:0]   cache_tag;
  logic [KEY_W-1:0]   cache_key;
  logic [4:0]         cnt;
  logic [4:0]         step_round;
  logic               dec;
  logic               cache_valid;
  logic               cache_hit;
  logic               last;
  logic               step_inv;

  assign cache_hit = cache_valid && (cache_tag == in_key);
  assign last      = (cnt == 5'(ROUNDS - 1));

  // Decrypt rounds walk the schedule backwards, so key_reg always holds the
  // key state of the round being executed and step_key the neighbouring one.
  assign step_inv   = (state == ROUND) && dec;
  assign step_round = step_inv ? (5'(ROUNDS) - cnt) : (cnt + 5'd1);

  present_key_step #(
    .KEY_W  (KEY_W),
    .KEY_ROT(KEY_ROT)
  ) u_key_step (
    .key      (key_reg),
    .round_idx(step_round),
    .decrypt  (step_inv),
    .next_key (step_key)
  );

  always_comb begin
    stage     = '0;
    round_out = '0;
    mixed     = data ^ key_reg[KEY_W-1 -: BLOCK_W];
    if (dec) begin
      stage     = BLOCK_W'(p_layer_inv(MAX_W'(mixed), BLOCK_W));
      round_out = BLOCK_W'(s_layer(MAX_W'(stage), BLOCK_W, 1'b1));
    end else begin
      stage     = BLOCK_W'(s_layer(MAX_W'(mixed), BLOCK_W, 1'b0));
      round_out = BLOCK_W'(p_layer(MAX_W'(stage), BLOCK_W));
    end
    // On the final round step_key is k_ROUNDS (encrypt) or k0 (decrypt).
    data_next = last ? (round_out ^ step_key[KEY_W-1 -: BLOCK_W]) : round_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_block  = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = (in_decrypt && !cache_hit) ? KEXP : ROUND;
      end
      KEXP: begin
        if (last) state_next = ROUND;
      end
      ROUND: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        out_block = data;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data        <= '0;
      key_reg     <= '0;
      cnt         <= '0;
      dec         <= 1'b0;
      cache_valid <= 1'b0;
      cache_tag   <= '0;
      cache_key   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data <= in_block;
            dec  <= in_decrypt;
            cnt  <= '0;
            key_reg <= (in_decrypt && cache_hit) ? cache_key : in_key;
            // The tag is claimed now but only trusted once expansion finishes.
            if (in_decrypt && !cache_hit) begin
              cache_valid <= 1'b0;
              cache_tag   <= in_key;
            end
          end
        end
        KEXP: begin
          key_reg <= step_key;
          cnt     <= last ? 5'd0 : cnt + 5'd1;
          if (last) begin
            cache_valid <= 1'b1;
            cache_key   <= step_key;
          end
        end
        ROUND: begin
          data    <= data_next;
          key_reg <= step_key;
          cnt     <= cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_present_iter_core.sv
// Self-checking bench: default-size core driven from a vector table plus
// corner sequences, then a 32-bit configuration run with random round trips.
module tb_present_iter_core;

  typedef struct {
    logic        dec;
    logic [31:0] blk;
    logic [39:0] key;
    logic [31:0] exp_blk;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] blk;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        in_valid;
  logic        in_decrypt;
  logic        out_ready;
  logic [31:0] in_block;
  logic [39:0] in_key;
  logic        d_in_ready, d_out_valid, w_in_ready, w_out_valid;
  logic [15:0] d_out_block;
  logic [31:0] w_out_block;
  logic        cur_in_ready, cur_out_valid;
  logic [31:0] cur_out_block;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t vecs[12];

  present_iter_core u_dut_d (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid && !sel),
    .in_ready  (d_in_ready),
    .in_decrypt(in_decrypt),
    .in_block  (in_block[15:0]),
    .in_key    (in_key[19:0]),
    .out_valid (d_out_valid),
    .out_ready (out_ready && !sel),
    .out_block (d_out_block)
  );

  present_iter_core #(
    .BLOCK_W(32),
    .KEY_W  (40),
    .ROUNDS (12),
    .KEY_ROT(15)
  ) u_dut_w (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid && sel),
    .in_ready  (w_in_ready),
    .in_decrypt(in_decrypt),
    .in_block  (in_block),
    .in_key    (in_key),
    .out_valid (w_out_valid),
    .out_ready (out_ready && sel),
    .out_block (w_out_block)
  );

  assign cur_in_ready  = sel ? w_in_ready  : d_in_ready;
  assign cur_out_valid = sel ? w_out_valid : d_out_valid;
  assign cur_out_block = sel ? w_out_block : {16'h0000, d_out_block};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #(5_000_000);
    $display("[TB] FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "[TB] simulation did not finish in time");
  end

  task automatic check_val(input string name, input logic [39:0] act, input logic [39:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Golden model, written straight from the algorithm description.
  function automatic logic [3:0] m_sbox(input logic [3:0] x);
    logic [3:0] y;
    y = 4'h0;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] m_isbox(input logic [3:0] x);
    logic [3:0] y;
    y = 4'h0;
    for (int v = 0; v < 16; v++) if (m_sbox(4'(v)) == x) y = 4'(v);
    return y;
  endfunction

  function automatic int m_dest(input int j, input int bw);
    if (j == bw - 1) return j;
    return (j * bw / 4) % (bw - 1);
  endfunction

  function automatic logic [31:0] m_sub(input logic [31:0] s, input int bw, input logic inv);
    logic [31:0] r;
    r = s;
    for (int c = 0; c < bw / 4; c++)
      r[5'(4 * c) +: 4] = inv ? m_isbox(s[5'(4 * c) +: 4]) : m_sbox(s[5'(4 * c) +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] m_perm(input logic [31:0] s, input int bw, input logic inv);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < bw; j++) begin
      if (!inv) r[5'(m_dest(j, bw))] = s[5'(j)];
      else      r[5'(j)] = s[5'(m_dest(j, bw))];
    end
    return r;
  endfunction

  function automatic logic [31:0] m_cipher(input logic dec, input logic [31:0] blk,
                                           input logic [39:0] key, input logic wide);
    int          bw;
    int          kw;
    int          rounds;
    logic [39:0] k;
    logic [39:0] t;
    logic [31:0] rk [32];
    logic [31:0] s;
    logic [3:0]  n;
    bw     = wide ? 32 : 16;
    kw     = wide ? 40 : 20;
    rounds = wide ? 12 : 7;
    k      = key;
    for (int i = 0; i <= rounds; i++) begin
      if (i > 0) begin
        t = '0;
        for (int b = 0; b < kw; b++) t[6'((b + 15) % kw)] = k[6'(b)];
        for (int q = 0; q < 4; q++) n[2'(q)] = t[6'(kw - 4 + q)];
        n = m_sbox(n);
        for (int q = 0; q < 4; q++) t[6'(kw - 4 + q)] = n[2'(q)];
        t[4:0] = t[4:0] ^ 5'(i);
        k = t;
      end
      rk[5'(i)] = '0;
      for (int b = 0; b < bw; b++) rk[5'(i)][5'(b)] = k[6'(kw - bw + b)];
    end
    s = blk;
    if (!dec) begin
      for (int r = 0; r < rounds; r++) s = m_perm(m_sub(s ^ rk[5'(r)], bw, 1'b0), bw, 1'b0);
      s = s ^ rk[5'(rounds)];
    end else begin
      for (int r = rounds; r >= 1; r--) s = m_sub(m_perm(s ^ rk[5'(r)], bw, 1'b1), bw, 1'b1);
      s = s ^ rk[0];
    end
    return s;
  endfunction

  // Handshake one request, then scramble the inputs so late changes are exercised.
  task automatic drive_request(input logic dec, input logic [31:0] blk, input logic [39:0] key);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!cur_in_ready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    check_val("in_ready_before_accept", 40'(cur_in_ready), 40'd1);
    in_decrypt = dec;
    in_block   = blk;
    in_key     = key;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_block   = $urandom();
    in_key     = {8'($urandom()), $urandom()};
    in_decrypt = 1'($urandom_range(0, 1));
  endtask

  task automatic apply_stimulus(input logic dec, input logic [31:0] blk, input logic [39:0] key,
                                input logic [31:0] exp_blk, input int exp_lat);
    exp_t e;
    e.blk = exp_blk;
    e.lat = exp_lat;
    sb.push_back(e);
    drive_request(dec, blk, key);
  endtask

  task automatic check_output(input string tag, input int hold);
    exp_t e;
    int   lat;
    e   = sb.pop_front();
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (cur_out_valid) break;
    end
    check_val($sformatf("%s_latency", tag), 40'(lat), 40'(e.lat));
    check_val($sformatf("%s_out_block", tag), 40'(cur_out_block), 40'(e.blk));
    for (int c = 0; c < hold; c++) begin
      @(posedge clk);
      #1;
      check_val($sformatf("%s_stall_valid", tag), 40'(cur_out_valid), 40'd1);
      check_val($sformatf("%s_stall_block", tag), 40'(cur_out_block), 40'(e.blk));
      check_val($sformatf("%s_stall_in_ready", tag), 40'(cur_in_ready), 40'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_val($sformatf("%s_idle_valid", tag), 40'(cur_out_valid), 40'd0);
    check_val($sformatf("%s_idle_in_ready", tag), 40'(cur_in_ready), 40'd1);
    check_val($sformatf("%s_idle_block", tag), 40'(cur_out_block), 40'd0);
  endtask

  initial begin
    logic [31:0] e0, ea, ef, e8, blk, ct;
    logic [39:0] key;
    int          seen;

    sel        = 1'b0;
    in_valid   = 1'b0;
    in_decrypt = 1'b0;
    in_block   = '0;
    in_key     = '0;
    out_ready  = 1'b0;
    rst_n      = 1'b0;

    @(posedge clk);
    #1;
    check_val("reset_out_valid", 40'(d_out_valid), 40'd0);
    check_val("reset_out_block", 40'(d_out_block), 40'd0);
    check_val("reset_w_out_valid", 40'(w_out_valid), 40'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("reset_in_ready", 40'(d_in_ready), 40'd1);
    check_val("reset_w_in_ready", 40'(w_in_ready), 40'd1);

    e0 = m_cipher(1'b0, 32'h0000, 40'h00000, 1'b0);
    ea = m_cipher(1'b0, 32'h1234, 40'hABCDE, 1'b0);
    ef = m_cipher(1'b0, 32'hFFFF, 40'hFFFFF, 1'b0);
    e8 = m_cipher(1'b0, 32'h8001, 40'hFFFFF, 1'b0);
    vecs[0]  = '{1'b0, 32'h0000, 40'h00000, e0, 7};
    vecs[1]  = '{1'b1, e0, 40'h00000, 32'h0000, 14};
    vecs[2]  = '{1'b1, e0, 40'h00000, 32'h0000, 7};
    vecs[3]  = '{1'b1, e0, 40'h00001, m_cipher(1'b1, e0, 40'h00001, 1'b0), 14};
    vecs[4]  = '{1'b1, e0, 40'h00000, 32'h0000, 14};
    vecs[5]  = '{1'b0, 32'h1234, 40'hABCDE, ea, 7};
    vecs[6]  = '{1'b1, ea, 40'hABCDE, 32'h1234, 14};
    vecs[7]  = '{1'b0, 32'hFFFF, 40'hFFFFF, ef, 7};
    vecs[8]  = '{1'b1, ef, 40'hFFFFF, 32'hFFFF, 14};
    vecs[9]  = '{1'b1, ef, 40'hFFFFF, 32'hFFFF, 7};
    vecs[10] = '{1'b0, 32'h8001, 40'hFFFFF, e8, 7};
    vecs[11] = '{1'b1, e8, 40'hFFFFF, 32'h8001, 7};

    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i].dec, vecs[i].blk, vecs[i].key, vecs[i].exp_blk, vecs[i].exp_lat);
      check_output($sformatf("vec%0d", i), 0);
    end

    // Consumer stalls for five cycles while the result is held.
    apply_stimulus(1'b0, 32'hC0DE, 40'h0F0F0, m_cipher(1'b0, 32'hC0DE, 40'h0F0F0, 1'b0), 7);
    check_output("stall", 5);

    // Reset in the third round cycle must drop the operation and flush the cache.
    drive_request(1'b0, 32'h5A5A, 40'h13579);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("abort_out_valid", 40'(d_out_valid), 40'd0);
    check_val("abort_out_block", 40'(d_out_block), 40'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (cur_out_valid) seen++;
    end
    check_val("abort_no_result", 40'(seen), 40'd0);
    check_val("abort_in_ready", 40'(cur_in_ready), 40'd1);
    apply_stimulus(1'b1, ef, 40'hFFFFF, 32'hFFFF, 14);
    check_output("post_reset_miss", 0);

    sel = 1'b1;
    for (int it = 0; it < 1000; it++) begin
      blk = $urandom();
      key = {8'($urandom()), $urandom()};
      ct  = m_cipher(1'b0, blk, key, 1'b1);
      apply_stimulus(1'b0, blk, key, ct, 12);
      check_output("wide_enc", 0);
      apply_stimulus(1'b1, ct, key, blk, 24);
      check_output("wide_dec_miss", 0);
      apply_stimulus(1'b1, ct, key, blk, 12);
      check_output("wide_dec_hit", 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
